// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the async FIFO write side, read side and pointer
// synchronizer.
//
// Contents:
//   FIFO_ADDR_WIDTH / FIFO_AF_LEVEL : default geometry and almost-full level
//   fifo_ptr_t                      : widest pointer the helpers handle
//   bin2gray / gray2bin             : width-generic Gray conversions
//
// The helpers work on a fixed 32-bit container. Callers zero-extend their
// pointer into it and truncate the result back. Zero upper bits pass
// through both conversions unchanged, so the low bits come out exactly as a
// conversion done at the pointer's own width.
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int FIFO_ADDR_WIDTH = 3;
  localparam int FIFO_AF_LEVEL   = 6;
  localparam int FIFO_PTR_MAXW   = 32;

  typedef logic [FIFO_PTR_MAXW-1:0] fifo_ptr_t;

  // Binary to Gray: each bit XORed with its upper neighbour.
  function automatic fifo_ptr_t bin2gray(input fifo_ptr_t b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: running XOR from the MSB down.
  function automatic fifo_ptr_t gray2bin(input fifo_ptr_t g);
    fifo_ptr_t b;
    b = g;
    for (int i = FIFO_PTR_MAXW-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_write_if.sv
// -----------------------------------------------------------------------------
// fifo_write_if
// Bundle between a FIFO producer and the write-side controller.
//
// Signals:
//   inc         producer -> ctrl  write request, one entry per cycle
//   sync_rptr   sync     -> ctrl  Gray read pointer, already in the clk domain
//   clr_ovf     producer -> ctrl  clears the sticky overflow flag
//   waddr       ctrl     -> mem   memory write address
//   wclken      ctrl     -> mem   memory write enable
//   full        ctrl     -> prod  FIFO full
//   overflow    ctrl     -> prod  sticky: write attempted while full
//   gray_w_ptr  ctrl     -> sync  registered Gray write pointer
//   almost_full ctrl     -> prod  only when FIFO_WR_ALMOST_FULL_EN is defined
//
// Modports: master = producer / surrounding logic, slave = fifo_write.
// -----------------------------------------------------------------------------
interface fifo_write_if import fifo_pkg::*; #(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) ();

  logic                  inc;
  logic [ADDR_WIDTH:0]   sync_rptr;
  logic                  clr_ovf;
  logic [ADDR_WIDTH-1:0] waddr;
  logic                  wclken;
  logic                  full;
  logic                  overflow;
  logic [ADDR_WIDTH:0]   gray_w_ptr;
`ifdef FIFO_WR_ALMOST_FULL_EN
  logic                  almost_full;
`endif

  modport master (
`ifdef FIFO_WR_ALMOST_FULL_EN
    input  almost_full,
`endif
    output inc, sync_rptr, clr_ovf,
    input  waddr, wclken, full, overflow, gray_w_ptr
  );

  modport slave (
`ifdef FIFO_WR_ALMOST_FULL_EN
    output almost_full,
`endif
    input  inc, sync_rptr, clr_ovf,
    output waddr, wclken, full, overflow, gray_w_ptr
  );

endinterface

// File: rtl/fifo_gray_reg.sv
// -----------------------------------------------------------------------------
// fifo_gray_reg
// Binary-in / Gray-out pointer register with synchronous active-high reset.
// Used for both the write and the read pointer. The output is a flop, so
// the value crossing into the other domain never glitches.
//
// Ports:
//   clk     clock
//   rst     synchronous reset, active high (output -> 0)
//   i_bin   binary pointer, WIDTH bits
//   o_gray  Gray code of i_bin, one cycle later
// -----------------------------------------------------------------------------
module fifo_gray_reg import fifo_pkg::*; #(
  parameter int WIDTH = FIFO_ADDR_WIDTH + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_bin,
  output logic [WIDTH-1:0] o_gray
);

  logic [WIDTH-1:0] r_gray;
  logic [WIDTH-1:0] w_gray;

  assign w_gray = WIDTH'(bin2gray(fifo_ptr_t'(i_bin)));

  always_ff @(posedge clk) begin
    if (rst) r_gray <= '0;
    else     r_gray <= w_gray;
  end

  assign o_gray = r_gray;

endmodule

// File: rtl/fifo_write.sv
// -----------------------------------------------------------------------------
// fifo_write
// Write-side pointer/flag controller of the async FIFO (write clock domain).
// Counts accepted writes in an (ADDR_WIDTH+1)-bit binary pointer whose MSB
// is the wrap bit. Drives the memory address/enable, publishes a registered
// Gray pointer for the read domain, and flags full/overflow.
//
// Ports:
//   clk   write-domain clock
//   rst   synchronous reset, active high; overrides every other input
//   bus   fifo_write_if.slave: inc, sync_rptr, clr_ovf in;
//         waddr, wclken, full, overflow, gray_w_ptr (, almost_full) out
//
// Parameters:
//   ADDR_WIDTH  memory address width, depth = 2**ADDR_WIDTH (>= 1)
//   AF_LEVEL    occupancy at/above which almost_full asserts, 1..2**ADDR_WIDTH
//
// Build option:
//   FIFO_WR_ALMOST_FULL_EN  adds the registered almost_full output together
//                           with the gray2bin + level subtractor behind it.
// -----------------------------------------------------------------------------
module fifo_write import fifo_pkg::*; #(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int AF_LEVEL   = FIFO_AF_LEVEL
) (
  input  logic         clk,
  input  logic         rst,
  fifo_write_if.slave  bus
);

  localparam int PW = ADDR_WIDTH + 1;

  // Full when the write pointer's Gray code equals the read pointer's Gray
  // code with its top two bits inverted: one full lap ahead. Inverting via
  // XOR with a mask also covers ADDR_WIDTH=1, where no low bits remain.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (ADDR_WIDTH - 1);

  if (AF_LEVEL < 1 || AF_LEVEL > (1 << ADDR_WIDTH)) begin : g_af_level_illegal
    $error("fifo_write: AF_LEVEL must lie in 1..2**ADDR_WIDTH");
  end

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_next;
  logic [PW-1:0] w_gray_now;
  logic          w_full;
  logic          w_wclken;
  logic          w_ovf_set;
  logic          r_ovf;

  // Full uses the live pointer, not the lagged registered Gray copy, so a
  // write on the edge that fills the FIFO is seen as full immediately.
  assign w_gray_now = PW'(bin2gray(fifo_ptr_t'(r_ptr)));
  assign w_full     = (w_gray_now == (bus.sync_rptr ^ FULL_MASK));
  assign w_wclken   = bus.inc & ~w_full;
  assign w_ovf_set  = bus.inc &  w_full;

  // Natural modulo-2**PW wrap; no extension bit.
  assign w_ptr_next = r_ptr + PW'(w_wclken);

  always_ff @(posedge clk) begin
    if (rst) r_ptr <= '0;
    else     r_ptr <= w_ptr_next;
  end

  // Gray copy of the pointer before this edge's advance. The one-cycle lag
  // only delays what the read side sees, so it can never read ahead of data.
  fifo_gray_reg #(.WIDTH(PW)) u_gray (
    .clk    (clk),
    .rst    (rst),
    .i_bin  (r_ptr),
    .o_gray (bus.gray_w_ptr)
  );

  // Sticky overflow; a new set beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst)               r_ovf <= 1'b0;
    else if (w_ovf_set)    r_ovf <= 1'b1;
    else if (bus.clr_ovf)  r_ovf <= 1'b0;
  end

  assign bus.waddr    = r_ptr[ADDR_WIDTH-1:0];
  assign bus.wclken   = w_wclken;
  assign bus.full     = w_full;
  assign bus.overflow = r_ovf;

`ifdef FIFO_WR_ALMOST_FULL_EN
  localparam logic [PW-1:0] AF_L = PW'(AF_LEVEL);

  logic [PW-1:0] w_rbin;
  logic [PW-1:0] w_level_next;
  logic          r_af;

  // Occupancy after this edge: post-increment write pointer minus the
  // (synchronized, hence possibly stale) read pointer. The mod-2**PW
  // difference stays within 0..2**ADDR_WIDTH.
  assign w_rbin       = PW'(gray2bin(fifo_ptr_t'(bus.sync_rptr)));
  assign w_level_next = w_ptr_next - w_rbin;

  // Registered, but full can only rise through a write on this same edge,
  // and that write pushes the level to depth >= AF_LEVEL, so almost_full is
  // always up whenever full is.
  always_ff @(posedge clk) begin
    if (rst) r_af <= 1'b0;
    else     r_af <= (w_level_next >= AF_L);
  end

  assign bus.almost_full = r_af;
`endif

endmodule

// File: tb/tb_fifo_write.sv
// -----------------------------------------------------------------------------
// tb_fifo_write
// Self-checking bench for fifo_write (ADDR_WIDTH=3, AF_LEVEL=6).
// The reference keeps plain integer write/read counts modulo 16 and derives
// everything from occupancy: full = 8 entries, waddr = count mod 8.
// Inputs change 1 time unit after a rising edge; outputs are sampled before
// the next edge (combinational) or just after it (registered).
// -----------------------------------------------------------------------------
module tb_fifo_write;

  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int PMOD  = 16;
  localparam int AF    = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_write_if #(.ADDR_WIDTH(AW)) bus ();

  fifo_write #(.ADDR_WIDTH(AW), .AF_LEVEL(AF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference state
  int         m_wp;    // accepted writes mod 16
  int         m_rp;    // reads visible to the write side, mod 16
  logic       m_ovf;
  logic [3:0] m_gray;  // expected registered Gray pointer
  logic       m_af;

  function automatic logic [3:0] g(input int v);
    return 4'((v ^ (v >> 1)) & 15);
  endfunction

  function automatic int occ();
    return (m_wp - m_rp + PMOD) % PMOD;
  endfunction

  function automatic logic exp_full();
    return occ() == DEPTH;
  endfunction

  task automatic drive(input bit i, input int rp, input bit c, input bit r = 1'b0);
    rst           = r;
    bus.inc       = i;
    m_rp          = rp % PMOD;
    bus.sync_rptr = g(m_rp);
    bus.clr_ovf   = c;
    #1;
  endtask

  // One clock edge, updating the reference by the behavioural rules.
  task automatic step();
    bit acc, blk;
    acc = bus.inc && !exp_full();
    blk = bus.inc &&  exp_full();
    @(posedge clk);
    if (rst) begin
      m_wp = 0; m_gray = 4'd0; m_ovf = 1'b0; m_af = 1'b0;
    end else begin
      m_gray = g(m_wp);
      if (blk)              m_ovf = 1'b1;
      else if (bus.clr_ovf) m_ovf = 1'b0;
      if (acc) m_wp = (m_wp + 1) % PMOD;
      m_af = (occ() >= AF);
    end
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 1);
    step();
  endtask

  task automatic test_reset();
    do_reset();
    drive(0, 0, 0);
    checks++; if (bus.waddr !== 3'd0) begin errors++; $display("FAIL reset_waddr: got %0d want 0", bus.waddr); end
    checks++; if (bus.gray_w_ptr !== 4'd0) begin errors++; $display("FAIL reset_gray: got %b want 0000", bus.gray_w_ptr); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", bus.overflow); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", bus.full); end
    checks++; if (bus.wclken !== 1'b0) begin errors++; $display("FAIL reset_wclken: got %b want 0", bus.wclken); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 0, 0);
      checks++; if (bus.waddr !== 3'(i) || bus.wclken !== 1'b1 || bus.full !== 1'b0) begin
        errors++; $display("FAIL fill[%0d]: got waddr=%0d wclken=%b full=%b want %0d 1 0", i, bus.waddr, bus.wclken, bus.full, i);
      end
      step();
    end
    drive(0, 0, 0);
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b want 1", bus.full); end
    step();
    checks++; if (bus.gray_w_ptr !== 4'b1100) begin errors++; $display("FAIL fill_gray: got %b want 1100", bus.gray_w_ptr); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0);
      checks++; if (bus.wclken !== 1'b0 || bus.waddr !== 3'd0) begin
        errors++; $display("FAIL ovf_block[%0d]: got wclken=%b waddr=%0d want 0 0", i, bus.wclken, bus.waddr);
      end
      step();
      checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set[%0d]: got %b want 1", i, bus.overflow); end
    end
    drive(0, 0, 1); step();
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", bus.overflow); end
    drive(1, 0, 1); step();
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_beats_clr: got %b want 1", bus.overflow); end
    checks++; if (bus.gray_w_ptr !== 4'b1100) begin errors++; $display("FAIL ovf_ptr_hold: got %b want 1100", bus.gray_w_ptr); end
    drive(0, 0, 1); step();
  endtask

  task automatic test_drain_refill();
    drive(0, 1, 0);
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL drain_full: got %b want 0", bus.full); end
    drive(1, 1, 0);
    checks++; if (bus.wclken !== 1'b1 || bus.waddr !== 3'd0) begin
      errors++; $display("FAIL refill_write: got wclken=%b waddr=%0d want 1 0", bus.wclken, bus.waddr);
    end
    step();
    drive(0, 1, 0);
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL refill_full: got %b want 1", bus.full); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < PMOD; i++) begin
      drive(1, (i < 3) ? 0 : i - 3, 0);
      checks++; if (bus.full !== 1'b0 || bus.waddr !== 3'(i % DEPTH)) begin
        errors++; $display("FAIL wrap_pre[%0d]: got full=%b waddr=%0d want 0 %0d", i, bus.full, bus.waddr, i % DEPTH);
      end
      step();
      checks++; if (bus.gray_w_ptr !== g(i)) begin errors++; $display("FAIL wrap_gray[%0d]: got %b want %b", i, bus.gray_w_ptr, g(i)); end
    end
    drive(0, 15, 0);
    checks++; if (bus.waddr !== 3'd0) begin errors++; $display("FAIL wrap_waddr: got %0d want 0", bus.waddr); end
    step();
    checks++; if (bus.gray_w_ptr !== 4'd0) begin errors++; $display("FAIL wrap_gray_end: got %b want 0000", bus.gray_w_ptr); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int i = 0; i < 9; i++) begin drive(1, 0, 0); step(); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL midrst_ovf_pre: got %b want 1", bus.overflow); end
    for (int i = 0; i < 2; i++) begin drive(1, 4, 0); step(); end
    drive(1, 0, 0, 1); step();
    drive(0, 0, 0);
    checks++; if (bus.waddr !== 3'd0 || bus.gray_w_ptr !== 4'd0 || bus.overflow !== 1'b0 || bus.full !== 1'b0) begin
      errors++; $display("FAIL midrst: got waddr=%0d gray=%b ovf=%b full=%b want 0 0000 0 0", bus.waddr, bus.gray_w_ptr, bus.overflow, bus.full);
    end
  endtask

  task automatic test_random();
    int nrp, adv;
    bit i, c, r;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      // Alternate write-heavy and read-heavy phases to reach both full and empty.
      if ((n / 60) % 2 == 0) begin
        i = ($urandom_range(0, 3) != 0); adv = ($urandom_range(0, 3) == 0) ? 1 : 0;
      end else begin
        i = ($urandom_range(0, 3) == 0); adv = $urandom_range(0, 2);
      end
      if (adv > occ()) adv = occ();
      nrp = (m_rp + adv) % PMOD;
      c = ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 149) == 0);
      if (r) nrp = 0;
      drive(i, nrp, c, r);
      if (!r) begin
        checks++; if (bus.full !== exp_full()) begin errors++; $display("FAIL rnd_full[%0d]: got %b want %b", n, bus.full, exp_full()); end
        checks++; if (bus.wclken !== (i && !exp_full())) begin errors++; $display("FAIL rnd_wclken[%0d]: got %b want %b", n, bus.wclken, i && !exp_full()); end
        checks++; if (bus.waddr !== 3'(m_wp % DEPTH)) begin errors++; $display("FAIL rnd_waddr[%0d]: got %0d want %0d", n, bus.waddr, m_wp % DEPTH); end
      end
      step();
      checks++; if (bus.gray_w_ptr !== m_gray) begin errors++; $display("FAIL rnd_gray[%0d]: got %b want %b", n, bus.gray_w_ptr, m_gray); end
      checks++; if (bus.overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf[%0d]: got %b want %b", n, bus.overflow, m_ovf); end
`ifdef FIFO_WR_ALMOST_FULL_EN
      checks++; if (bus.almost_full !== m_af) begin errors++; $display("FAIL rnd_af[%0d]: got %b want %b", n, bus.almost_full, m_af); end
`endif
    end
  endtask

`ifdef FIFO_WR_ALMOST_FULL_EN
  task automatic test_almost_full();
    do_reset();
    checks++; if (bus.almost_full !== 1'b0) begin errors++; $display("FAIL af_reset: got %b want 0", bus.almost_full); end
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1, 0, 0); step();
      checks++; if (bus.almost_full !== (i >= AF)) begin errors++; $display("FAIL af_write[%0d]: got %b want %b", i, bus.almost_full, i >= AF); end
    end
    drive(0, 0, 0);
    checks++; if (bus.full !== 1'b1 || bus.almost_full !== 1'b1) begin
      errors++; $display("FAIL af_at_full: got full=%b af=%b want 1 1", bus.full, bus.almost_full);
    end
  endtask
`endif

  initial begin
    m_wp = 0; m_rp = 0; m_ovf = 1'b0; m_gray = 4'd0; m_af = 1'b0;
    drive(0, 0, 0, 1);
    test_reset();
    test_fill();
    test_overflow();
    test_drain_refill();
    test_wrap();
    test_reset_mid_burst();
`ifdef FIFO_WR_ALMOST_FULL_EN
    test_almost_full();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_write.md
Name: fifo_write

Overview:
- Write-side pointer/flag controller for the async FIFO; the counterpart of the existing read-side controller.
- Lives in the write clock domain. Takes write requests, advances a binary write pointer and drives the memory write address and write enable.
- Publishes a Gray-coded write pointer for the read-domain synchronizer.
- Computes full from the synchronized Gray read pointer; also offers a sticky overflow flag and an optional almost-full flag.

Parameters:
- ADDR_WIDTH, 3, memory address width; FIFO depth = 2**ADDR_WIDTH (default 8 entries).
- AF_LEVEL, 6, occupancy at or above which almost_full asserts (optional feature only); legal range 1..2**ADDR_WIDTH.

Ports:
- clk  input  1  write-domain clock.
- rst  input  1  reset, synchronous, active-high.
- inc  input  1  write request; one entry per cycle while high.
- sync_rptr  input  ADDR_WIDTH+1  Gray read pointer, already 2-FF synchronized into clk domain.
- clr_ovf  input  1  clears the sticky overflow flag.
- waddr  output  ADDR_WIDTH  memory write address = w_ptr[ADDR_WIDTH-1:0].
- wclken  output  1  memory write enable = inc & ~full.
- full  output  1  FIFO full.
- overflow  output  1  sticky: a write was attempted while full.
- gray_w_ptr  output  ADDR_WIDTH+1  registered Gray write pointer, for the read-domain synchronizer.
- almost_full  output  1  present only with FIFO_WR_ALMOST_FULL_EN.

Behaviour:
- Internal w_ptr is an (ADDR_WIDTH+1)-bit binary pointer. The MSB is the wrap bit; the pointer wraps modulo 2**(ADDR_WIDTH+1).
- Reset (rst high at a clk edge): w_ptr=0, gray_w_ptr=0, overflow=0.
  - This gives waddr=0 and full=0 (because sync_rptr is reset to 0 upstream).
  - rst has priority over every other input, including in the middle of a burst.
- Advance: on a clk edge with inc=1 and full=0, w_ptr <= w_ptr+1. No other condition changes w_ptr.
- wclken: combinational, inc & ~full. The memory captures wdata at waddr on the same edge that w_ptr advances.
- Gray pointer: gray_w_ptr <= bin2gray(w_ptr) every cycle, so it lags w_ptr by one cycle.
  - bin2gray(b) = b ^ (b>>1).
  - The lag only delays visibility to the read side. It is conservative: the read side can never see data that has not been written.
- Full: combinational, computed from the current (unlagged) pointer.
  - full = (bin2gray(w_ptr) == {~sync_rptr[ADDR_WIDTH:ADDR_WIDTH-1], sync_rptr[ADDR_WIDTH-2:0]}).
  - For ADDR_WIDTH=1 the low slice is empty; compare only the two inverted MSBs.
- Full is pessimistic: it deasserts no earlier than 2 clk cycles after the read side actually frees a slot (synchronizer latency).
- Overflow: set on an edge with inc=1 & full=1. Held until clr_ovf=1 or rst.
  - If a set and clr_ovf coincide on the same edge, the set wins and overflow stays 1.
  - An overflowing write is dropped: w_ptr holds and wclken=0.
- Wrap-around: after 2**(ADDR_WIDTH+1) accepted writes, w_ptr returns to 0 and behaviour is unchanged. No width extension anywhere.
- sync_rptr may change on any cycle. Full re-evaluates combinationally the same cycle.

Optional Feature:
- Macro: FIFO_WR_ALMOST_FULL_EN.
- When defined:
  - Port almost_full exists.
  - rbin = gray2bin(sync_rptr) (prefix XOR from the MSB down).
  - level = (w_ptr - rbin) mod 2**(ADDR_WIDTH+1), giving a range of 0..2**ADDR_WIDTH.
  - almost_full is registered: almost_full <= (level_next >= AF_LEVEL), where level_next uses the post-increment w_ptr. Reset value 0.
  - almost_full is always 1 whenever full is 1.
- When undefined: no almost_full port, no gray2bin logic, no level subtractor.

Decomposition:
- Package fifo_pkg:
  - Functions bin2gray and gray2bin, parameterized by width.
  - Default constants FIFO_ADDR_WIDTH=3 and FIFO_AF_LEVEL=6, shared with the read side and the synchronizer.
- Sub-module fifo_gray_reg: (ADDR_WIDTH+1)-bit binary-in / Gray-out register with synchronous reset. Reusable on the read side.
- Full compare, overflow flag and optional level logic stay in fifo_write.

Test Plan:
- Reset/fill, ADDR_WIDTH=3, sync_rptr held at 0: 8 writes with inc=1 -> waddr 0..7, wclken high 8 cycles; full=1 after the 8th edge; gray_w_ptr=4'b1100 one cycle later.
- Overflow: FIFO full, inc=1 for 2 cycles -> w_ptr holds, wclken=0, overflow=1. Pulse clr_ovf -> overflow=0. clr_ovf together with a blocked write -> overflow stays 1.
- Drain/refill: full, then drive sync_rptr=4'b0001 (1 read) -> full=0 the same cycle. One write -> full=1 again, waddr was 0.
- Wrap: 16 writes interleaved with matching sync_rptr steps -> w_ptr returns to 0, gray_w_ptr sequence matches bin2gray at each step, full never falsely asserts.
- Reset mid-burst: rst=1 after 5 writes -> next cycle waddr=0, gray_w_ptr=0, overflow=0, full=0 with sync_rptr=0.
- FIFO_WR_ALMOST_FULL_EN defined, AF_LEVEL=6, sync_rptr=0: after the 5th write almost_full=0; on the edge accepting the 6th write almost_full=1; it stays 1 through full.
